// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared types and constants for the sequential restoring
//               divider: FSM state encoding, default width, iteration
//               counter width and the saturation pattern returned on
//               divide-by-zero / overflow.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

  localparam int DIV_DEFAULT_WIDTH = 32;

  // Iteration counter width for the default build (counts 0 .. WIDTH-1).
  localparam int DIV_CNT_W = $clog2(DIV_DEFAULT_WIDTH);

  // Quotient value reported when the true quotient cannot be represented.
  localparam logic [DIV_DEFAULT_WIDTH-1:0] DIV_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_if
// Description : Operand / result bus of the sequential divider with a
//               start/done handshake.
//   master : drives start, dividend, divisor; observes the results
//   slave  : the divider; drives busy, done, quotient, remainder,
//            div_by_zero, overflow, check_err
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
);

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;
  logic                 check_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow, check_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow, check_err
  );

endinterface : seq_divider_if
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_div_step
// Description : One restoring-division iteration (combinational).
//   i_rem     : partial remainder (always < divisor between steps)
//   i_q       : partially shifted dividend / quotient register
//   i_divisor : divisor
//   o_rem     : partial remainder after shift and trial subtract
//   o_q       : quotient register after shift with new quotient bit
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q
);

  // Shifted remainder needs one extra bit; the top bit of {rem,q} is only
  // transient because the incoming remainder is already below the divisor.
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  assign w_rem_sh = {i_rem, i_q[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, i_divisor});
  // When w_ge holds the true difference is < divisor, so WIDTH bits suffice.
  assign w_diff   = w_rem_sh[WIDTH-1:0] - i_divisor;

  assign o_rem = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
  assign o_q   = {i_q[WIDTH-2:0], w_ge};

endmodule : seq_divider_div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential restoring divider, 2*WIDTH / WIDTH unsigned,
//               one quotient bit per clock, start/done handshake.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : seq_divider_if.slave (operands in, results/status out)
// Optional    : DIV_SELFCHECK_EN - registered quotient*divisor+remainder
//               check against the captured dividend, reported on check_err
//               the cycle after done (WIDTH must be 32).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  localparam int              CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] q_q,         q_d;
  logic [WIDTH-1:0] divisor_q,   divisor_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;
  logic             ovf_q,       ovf_d;

  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_q;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_accept;
  logic             w_run_finish;

  assign w_hi         = bus.dividend[2*WIDTH-1:WIDTH];
  assign w_lo         = bus.dividend[WIDTH-1:0];
  // Start is honoured in IDLE and in the DONE cycle (back-to-back ops).
  assign w_accept     = bus.start && (state_q != S_RUN);
  assign w_run_finish = (state_q == S_RUN) && (count_q == LAST_STEP);

  seq_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem     (rem_q),
    .i_q       (q_q),
    .i_divisor (divisor_q),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_RUN: begin
        rem_d   = w_step_rem;
        q_d     = w_step_q;
        count_d = count_q + CNT_W'(1);
        if (w_run_finish) begin
          state_d     = S_DONE;
          quotient_d  = w_step_q;
          remainder_d = w_step_rem;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      default: begin
        // IDLE, DONE (and the unused encoding) fall back to IDLE.
        state_d = S_IDLE;
        if (w_accept) begin
          if (bus.divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = w_lo;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
          end else if (w_hi >= bus.divisor) begin
            // Quotient would need more than WIDTH bits: saturate.
            state_d     = S_DONE;
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = w_hi;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
          end else begin
            state_d   = S_RUN;
            rem_d     = w_hi;
            q_d       = w_lo;
            divisor_d = bus.divisor;
            count_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

`ifdef DIV_SELFCHECK_EN
  localparam int DW = 2 * WIDTH;

  if (WIDTH != 32) begin : g_selfcheck_width
    $error("seq_divider: DIV_SELFCHECK_EN requires WIDTH == 32");
  end

  logic [DW-1:0] dividend_q, dividend_d;
  logic [DW-1:0] prod_q,     prod_d;
  logic          chk_pend_q, chk_pend_d;
  logic          check_err_q, check_err_d;

  // Product is registered on entry to DONE; the sum/compare happens in the
  // DONE cycle so check_err lands one cycle after done. Saturated ops never
  // arm the check.
  always_comb begin
    dividend_d  = dividend_q;
    prod_d      = prod_q;
    chk_pend_d  = 1'b0;
    if (w_accept) begin
      dividend_d = bus.dividend;
    end
    if (w_run_finish) begin
      prod_d     = DW'(w_step_q) * DW'(divisor_q);
      chk_pend_d = 1'b1;
    end
    check_err_d = chk_pend_q && ((prod_q + DW'(remainder_q)) != dividend_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_q  <= '0;
      prod_q      <= '0;
      chk_pend_q  <= 1'b0;
      check_err_q <= 1'b0;
    end else begin
      dividend_q  <= dividend_d;
      prod_q      <= prod_d;
      chk_pend_q  <= chk_pend_d;
      check_err_q <= check_err_d;
    end
  end

  assign bus.check_err = check_err_q;
`else
  assign bus.check_err = 1'b0;
`endif

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed, self-checking bench for seq_divider (WIDTH=32).
//               Inputs are driven and outputs sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) dif ();

  seq_divider #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  int   n_done;
  logic busy_seen;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents an op at the current falling edge and waits (bounded) for done.
  // lat_o counts rising edges from the accepting edge (inclusive) to done.
  task automatic run_op(input logic [63:0] dvd, input logic [31:0] dvs,
                        output int lat_o, output logic busy_o);
    dif.dividend = dvd;
    dif.divisor  = dvs;
    dif.start    = 1'b1;
    lat_o        = 0;
    busy_o       = 1'b0;
    do begin
      @(posedge clk);
      lat_o++;
      @(negedge clk);
      dif.start = 1'b0;
      if (dif.busy) busy_o = 1'b1;
    end while (!dif.done && lat_o < 100);
  endtask

  task automatic check_result(input string tag, input int exp_lat,
                              input logic exp_busy, input logic [31:0] exp_q,
                              input logic [31:0] exp_r, input logic exp_dbz,
                              input logic exp_ovf);
    check_val({tag, "_lat"},  64'(lat), 64'(exp_lat));
    check_val({tag, "_busy"}, busy_seen, exp_busy);
    check_val({tag, "_q"},    dif.quotient, exp_q);
    check_val({tag, "_r"},    dif.remainder, exp_r);
    check_val({tag, "_dbz"},  dif.div_by_zero, exp_dbz);
    check_val({tag, "_ovf"},  dif.overflow, exp_ovf);
    check_val({tag, "_cerr"}, dif.check_err, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check_val("rst_busy", dif.busy, 1'b0);
    check_val("rst_done", dif.done, 1'b0);
    check_val("rst_q",    dif.quotient, 32'h0);
    check_val("rst_r",    dif.remainder, 32'h0);
    check_val("rst_flags", {dif.div_by_zero, dif.overflow, dif.check_err}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    // Basic op: 100 / 7 = 14 r 2
    run_op(64'd100, 32'd7, lat, busy_seen);
    check_result("d100_7", 33, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_val("done_pulse", dif.done, 1'b0);
    check_val("hold_q", dif.quotient, 32'd14);

    // Largest representable quotient: (2^32-1)^2 / (2^32-1)
    run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, lat, busy_seen);
    check_result("max", 33, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);

    // Divide by zero
    run_op(64'h1234_5678_9ABC_DEF0, 32'h0, lat, busy_seen);
    check_result("dbz", 1, 1'b0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0);
    @(negedge clk);

    // Overflow boundary: high half equals divisor
    run_op(64'h0000_0001_0000_0000, 32'h1, lat, busy_seen);
    check_result("ovf", 1, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    @(negedge clk);

    // 5*2^32 / 16 = 0x5000_0000 r 0 ; 7 / 100 = 0 r 7
    run_op(64'h0000_0005_0000_0000, 32'h10, lat, busy_seen);
    check_result("shift", 33, 1'b1, 32'h5000_0000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    run_op(64'd7, 32'd100, lat, busy_seen);
    check_result("small", 33, 1'b1, 32'h0, 32'd7, 1'b0, 1'b0);
    @(negedge clk);

    // Start pulsed at cycle 10 of 1000/3 must be ignored (333 r 1)
    dif.dividend = 64'd1000;
    dif.divisor  = 32'd3;
    dif.start    = 1'b1;
    lat          = 0;
    busy_seen    = 1'b0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      dif.start = (lat == 10);
      if (lat == 10) begin
        dif.dividend = 64'd50;
        dif.divisor  = 32'd5;
      end
      if (dif.busy) busy_seen = 1'b1;
    end while (!dif.done && lat < 100);
    check_result("ign", 33, 1'b1, 32'd333, 32'd1, 1'b0, 1'b0);

    // Back-to-back: start during DONE cycle; 0xFFFFFFFF / 16
    check_val("b2b_in_done", dif.done, 1'b1);
    run_op(64'h0000_0000_FFFF_FFFF, 32'h10, lat, busy_seen);
    check_result("b2b", 33, 1'b1, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);

    // Reset at cycle 15 of RUN aborts the op and clears the outputs
    dif.dividend = 64'd100;
    dif.divisor  = 32'd7;
    dif.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    repeat (14) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val("mid_busy", dif.busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_busy", dif.busy, 1'b0);
    check_val("abort_done", dif.done, 1'b0);
    check_val("abort_q",    dif.quotient, 32'h0);
    check_val("abort_r",    dif.remainder, 32'h0);
    check_val("abort_flags", {dif.div_by_zero, dif.overflow, dif.check_err}, 3'b000);
    reset  = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (dif.done) n_done++;
    end
    check_val("abort_no_done", 64'(n_done), 64'd0);

    run_op(64'd100, 32'd7, lat, busy_seen);
    check_result("after_rst", 33, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_divider
`default_nettype wire
